// File: rtl/nios_ii_system_pio_pkg.sv
// Shared constants for the Nios II system parallel I/O ports.
// Register addresses, edge-select encodings and a width helper.
package nios_ii_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/nios_ii_system_key_debounce.sv
// Single-bit debouncer: dout follows din only after din has
// disagreed with dout for CYCLES consecutive clocks.
module nios_ii_system_key_debounce
  import nios_ii_system_pio_pkg::*;
#(
  parameter logic [15:0] CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = clog2(int'(CYCLES) + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 16'd1);

  logic [CW-1:0] cnt;

  // Count disagreeing cycles; any agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      dout <= din;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nios_ii_system_key_in.sv
// Avalon-MM input PIO with per-bit edge capture and maskable irq.
// Optional per-bit debounce when KEY_IN_DEBOUNCE_EN is defined.
module nios_ii_system_key_in
  import nios_ii_system_pio_pkg::*;
#(
  parameter int          WIDTH           = 4,
  parameter int          EDGE_TYPE       = 1,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cond;
  logic [WIDTH-1:0] cond_d;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_det;
  logic [31:0]      rd_mux;
  logic             rd_en;
  logic             wr_en;
  logic             unused_ok;

  assign rd_en = chipselect & write_n;
  assign wr_en = chipselect & ~write_n;
  assign unused_ok = ^{writedata, DEBOUNCE_CYCLES};

  // Two-flop synchronizer for the asynchronous pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef KEY_IN_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    nios_ii_system_key_debounce #(
      .CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .din  (sync2[i]),
      .dout (cond[i])
    );
  end
`else
  assign cond = sync2;
`endif

  // Previous conditioned value for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cond_d <= '0;
    else       cond_d <= cond;
  end

  assign rise = cond & ~cond_d;
  assign fall = ~cond & cond_d;

  // Select which edge polarity is captured.
  always_comb begin
    edge_det = rise | fall;
    unique case (EDGE_TYPE)
      EDGE_RISE: edge_det = rise;
      EDGE_FALL: edge_det = fall;
      default:   edge_det = rise | fall;
    endcase
  end

  // Sticky capture; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_capture <= '0;
    end else if (wr_en && address == ADDR_EDGECAP) begin
      edge_capture <= (edge_capture & ~writedata[WIDTH-1:0])
                    | edge_det;
    end else begin
      edge_capture <= edge_capture | edge_det;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
    end else if (wr_en && address == ADDR_IRQMASK) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  assign irq = |(edge_capture & irq_mask);

  // Zero-extended read mux.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = cond;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_capture;
      default:      rd_mux = '0;
    endcase
  end

  // Registered read data, zero when not reading.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      readdata <= '0;
    else if (rd_en) readdata <= rd_mux;
    else            readdata <= '0;
  end

endmodule

// File: tb/tb_nios_ii_system_key_in.sv
// Directed self-checking bench for nios_ii_system_key_in.
// Debounce glitch vectors run when KEY_IN_DEBOUNCE_EN is defined.
module tb_nios_ii_system_key_in;

  localparam int DEB = 8;
`ifdef KEY_IN_DEBOUNCE_EN
  localparam int EDGE_LAT = 3 + DEB;
`else
  localparam int EDGE_LAT = 3;
`endif
  localparam int SETTLE = EDGE_LAT + 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int n_chk = 0;
  int n_pass = 0;

  nios_ii_system_key_in #(
    .WIDTH          (4),
    .EDGE_TYPE      (1),
    .DEBOUNCE_CYCLES(16'(DEB))
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  task automatic rd(input logic [1:0] a, input string tag,
                    input logic [31:0] exp);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    check(tag, readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wait_irq(input logic v, input int budget,
                          input string tag);
    for (int i = 0; i < budget && irq !== v; i++) @(negedge clk);
    check(tag, {31'b0, irq}, {31'b0, v});
  endtask

  task automatic settle();
    repeat (SETTLE) @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'b1111;
    #12;
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    settle();

    // Idle-high keys after reset: rising only, not captured.
    rd(2'd0, "data_idle", 32'h0000000F);
    check("idle_irq", {31'b0, irq}, 32'h0);
    rd(2'd1, "addr1_zero", 32'h0);
    wr(2'd0, 32'h5);
    rd(2'd0, "data_ro", 32'h0000000F);
    rd(2'd3, "cap_after_rst", 32'h0);
    rd(2'd2, "mask_rst", 32'h0);

    // Falling edge on bit 1 with mask bit 1.
    wr(2'd2, 32'h2);
    in_port = 4'b1101;
    wait_irq(1'b1, EDGE_LAT + 4, "fall1_irq");
    rd(2'd3, "fall1_cap", 32'h2);
    wr(2'd3, 32'h2);
    check("clr_irq", {31'b0, irq}, 32'h0);
    rd(2'd3, "clr_cap", 32'h0);

    // Rising edge is ignored for falling-edge capture.
    in_port = 4'b1111;
    settle();
    rd(2'd3, "rise_ignored", 32'h0);
    check("rise_irq", {31'b0, irq}, 32'h0);

    // Masked capture on bit 3, then unmask.
    wr(2'd2, 32'h0);
    in_port = 4'b0111;
    settle();
    rd(2'd3, "fall3_cap", 32'h8);
    check("fall3_masked", {31'b0, irq}, 32'h0);
    wr(2'd2, 32'h8);
    check("unmask_irq", {31'b0, irq}, 32'h1);
    rd(2'd2, "mask_rd", 32'h8);

    in_port = 4'b1111;
    settle();
    wr(2'd3, 32'hF);
    wr(2'd2, 32'h0);
    rd(2'd3, "cap_cleared", 32'h0);

    // Clear-write on bit 0 in the very cycle its edge lands.
    in_port = 4'b1110;
    repeat (EDGE_LAT - 1) @(negedge clk);
    wr(2'd3, 32'h1);
    rd(2'd3, "set_wins", 32'h1);
    wr(2'd3, 32'h0);
    rd(2'd3, "zero_write", 32'h1);

    // Asynchronous reset with captures and irq pending.
    in_port = 4'b1000;
    settle();
    wr(2'd3, 32'h1);
    wr(2'd2, 32'hF);
    check("pre_rst_irq", {31'b0, irq}, 32'h1);
    address    = 2'd3;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    check("pre_rst_rd", readdata, 32'h6);
    #2;
    reset = 1'b1;
    #1;
    check("async_rd", readdata, 32'h0);
    check("async_irq", {31'b0, irq}, 32'h0);
    check("async_cap", {28'b0, dut.edge_capture}, 32'h0);
    check("async_mask", {28'b0, dut.irq_mask}, 32'h0);
    @(negedge clk);
    chipselect = 1'b0;
    reset      = 1'b0;
    in_port    = 4'b1111;
    settle();
    rd(2'd3, "post_rst_cap", 32'h0);
    rd(2'd2, "post_rst_mask", 32'h0);

`ifdef KEY_IN_DEBOUNCE_EN
    // Short glitch is filtered; long low is captured.
    in_port = 4'b1011;
    repeat (5) @(negedge clk);
    in_port = 4'b1111;
    settle();
    rd(2'd3, "glitch5", 32'h0);
    in_port = 4'b1011;
    repeat (9) @(negedge clk);
    in_port = 4'b1111;
    settle();
    rd(2'd3, "low9", 32'h4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
